tug_round_ctrl: RTL and testbench

- Round sequencer for the tug-of-war game; sits between the push-button latch and the LED rope display.
- Each round: arms the latch, waits a (pseudo-)random delay, raises GO, then reads push/tie/right from the latch.
- Moves the rope one step toward the first presser and detects the win at either end.

---
 rtl/tug_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tug_round_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tug_round_ctrl.sv
// tug_round_ctrl
//   Round sequencer for the tug-of-war game. Each round it arms the push-button
//   latch, waits a pseudo-random delay, lights GO, then reads the latch result
//   and moves the rope one step toward the first presser. A win is detected
//   when the rope reaches either end.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pbl, pbr  in   left/right buttons (synchronized), used only for fouls/release
//   new_game  in   level, restarts play from WIN
//   push      in   latch: some player pressed
//   tie       in   latch: both pressed together
//   right     in   latch: right player pressed first
//   clear     out  latch clear (high everywhere except GO)
//   go        out  GO lamp
//   leds      out  one-hot rope position, bit 0 = left end
//   win_l     out  left player won
//   win_r     out  right player won
//   foul      out  one-cycle pulse on a press during the delay
module tug_round_ctrl #(
   parameter int NUM_POS    = 9,
   parameter int MIN_DELAY  = 16,
   parameter int RAND_BITS  = 4,
   parameter int GO_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pbl,
   input  logic               pbr,
   input  logic               new_game,
   input  logic               push,
   input  logic               tie,
   input  logic               right,
   output logic               clear,
   output logic               go,
   output logic [NUM_POS-1:0] leds,
   output logic               win_l,
   output logic               win_r,
   output logic               foul
);

   localparam int CENTRE = (NUM_POS - 1) / 2;
   localparam int DW     = $clog2(MIN_DELAY + (1 << RAND_BITS)) + 1;
   localparam int TW     = $clog2(GO_TIMEOUT) + 1;
   // Low RAND_BITS of the LFSR; an all-zero mask gives a fixed delay.
   localparam logic [7:0] RMASK = 8'((1 << RAND_BITS) - 1);
   localparam logic [NUM_POS-1:0] LED_CTR = {{(NUM_POS-1){1'b0}}, 1'b1} << CENTRE;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_REL, S_DELAY, S_GO, S_SCORE, S_CHECK, S_WIN
   } state_t;

   state_t             state_q;
   logic [7:0]         lfsr_q;
   logic [DW-1:0]      dly_q;
   logic [TW-1:0]      tmo_q;
   logic               tie_q, right_q;
   logic [NUM_POS-1:0] leds_q;
   logic               clear_q, go_q, win_l_q, win_r_q, foul_q;

   logic               lfsr_fb;
   logic [DW-1:0]      dly_load;

   // Fibonacci LFSR, taps 8,6,5,4.
   assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign dly_load = DW'(MIN_DELAY) + DW'(lfsr_q & RMASK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= 8'hA5;
      else      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
   end

   // The rope position is held directly as the one-hot leds register.
   // go/clear are only changed on transitions into or out of GO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dly_q   <= '0;
         tmo_q   <= '0;
         tie_q   <= 1'b0;
         right_q <= 1'b0;
         leds_q  <= LED_CTR;
         clear_q <= 1'b1;
         go_q    <= 1'b0;
         win_l_q <= 1'b0;
         win_r_q <= 1'b0;
         foul_q  <= 1'b0;
      end else begin
         foul_q <= 1'b0;
         case (state_q)
            S_IDLE: state_q <= S_WAIT_REL;
            S_WAIT_REL: begin
               if (!pbl && !pbr) begin
                  dly_q   <= dly_load;
                  state_q <= S_DELAY;
               end
            end
            S_DELAY: begin
               // A press beats expiry in the same cycle.
               if (pbl || pbr) begin
                  foul_q  <= 1'b1;
                  state_q <= S_WAIT_REL;
               end else if (dly_q == DW'(1)) begin
                  tmo_q   <= '0;
                  go_q    <= 1'b1;
                  clear_q <= 1'b0;
                  state_q <= S_GO;
               end else begin
                  dly_q <= dly_q - DW'(1);
               end
            end
            S_GO: begin
               if (push) begin
                  tie_q   <= tie;
                  right_q <= right;
                  go_q    <= 1'b0;
                  clear_q <= 1'b1;
                  state_q <= S_SCORE;
               end else if (tmo_q == TW'(GO_TIMEOUT - 1)) begin
                  go_q    <= 1'b0;
                  clear_q <= 1'b1;
                  state_q <= S_WAIT_REL;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_SCORE: begin
               // tie outranks right; end guards keep the rope one-hot.
               if (!tie_q) begin
                  if (right_q) begin
                     if (!leds_q[NUM_POS-1]) leds_q <= leds_q << 1;
                  end else begin
                     if (!leds_q[0]) leds_q <= leds_q >> 1;
                  end
               end
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (leds_q[NUM_POS-1]) begin
                  win_r_q <= 1'b1;
                  state_q <= S_WIN;
               end else if (leds_q[0]) begin
                  win_l_q <= 1'b1;
                  state_q <= S_WIN;
               end else begin
                  state_q <= S_WAIT_REL;
               end
            end
            S_WIN: begin
               if (new_game) begin
                  leds_q  <= LED_CTR;
                  win_l_q <= 1'b0;
                  win_r_q <= 1'b0;
                  state_q <= S_WAIT_REL;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign clear = clear_q;
   assign go    = go_q;
   assign leds  = leds_q;
   assign win_l = win_l_q;
   assign win_r = win_r_q;
   assign foul  = foul_q;

endmodule

// File: tb/tb_tug_round_ctrl.sv
module tb_tug_round_ctrl;
   localparam int NP  = 5;
   localparam int MD  = 4;
   localparam int RB  = 0;
   localparam int GT  = 8;
   localparam int CTR = (NP - 1) / 2;

   logic clk = 1'b0, rst = 1'b1;
   logic pbl = 1'b0, pbr = 1'b0, new_game = 1'b0;
   logic push = 1'b0, tie = 1'b0, right = 1'b0;
   logic clear, go, win_l, win_r, foul;
   logic [NP-1:0] leds;

   int total = 0;
   int bad   = 0;
   int pos;  // reference rope position, 0 = left end

   always #5 clk = ~clk;

   tug_round_ctrl #(.NUM_POS(NP), .MIN_DELAY(MD), .RAND_BITS(RB), .GO_TIMEOUT(GT)) dut (
      .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .new_game(new_game),
      .push(push), .tie(tie), .right(right), .clear(clear), .go(go),
      .leds(leds), .win_l(win_l), .win_r(win_r), .foul(foul)
   );

   function automatic logic [NP-1:0] exp_leds(input int p);
      logic [NP-1:0] one;
      one = 1;
      return one << p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles until go rises; -1 if it never does within the budget.
   task automatic wait_go(output int n);
      n = 0;
      while (go !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (go !== 1'b1) n = -1;
   endtask

   // Starts in the first observed GO cycle, ends in the next GO cycle.
   // fl: 0 = no foul, k>0 = press during DELAY cycle k of the next round.
   task automatic push_round(input bit t, input bit r, input int fl);
      int n;
      push = 1'b1; tie = t; right = r;
      tick();
      push = 1'b0; tie = 1'b0; right = 1'b0;
      total++; if ({go, clear, foul} !== 3'b010) begin bad++; $display("FAIL score_ctl got=%b exp=010", {go, clear, foul}); end
      total++; if (leds !== exp_leds(pos)) begin bad++; $display("FAIL score_hold got=%b exp=%b", leds, exp_leds(pos)); end
      tick();
      if (!t) pos = r ? pos + 1 : pos - 1;
      total++; if (leds !== exp_leds(pos)) begin bad++; $display("FAIL move_leds t=%0d r=%0d got=%b exp=%b", t, r, leds, exp_leds(pos)); end
      if (pos == 0 || pos == NP - 1) begin
         tick();
         total++; if ({win_l, win_r} !== {pos == 0, pos == NP - 1}) begin bad++; $display("FAIL win_flags got=%b pos=%0d", {win_l, win_r}, pos); end
         repeat ($urandom_range(0, 3)) tick();
         total++; if ({win_l, win_r, go, clear} !== {pos == 0, pos == NP - 1, 1'b0, 1'b1} || leds !== exp_leds(pos)) begin
            bad++; $display("FAIL win_hold got=%b leds=%b pos=%0d", {win_l, win_r, go, clear}, leds, pos);
         end
         new_game = 1'b1;
         tick();
         new_game = 1'b0;
         pos = CTR;
         total++; if ({win_l, win_r} !== 2'b00 || leds !== exp_leds(pos)) begin bad++; $display("FAIL new_game wins=%b leds=%b exp=%b", {win_l, win_r}, leds, exp_leds(pos)); end
         wait_go(n);
         total++; if (n !== MD + 1) begin bad++; $display("FAIL go_after_new_game got=%0d exp=%0d", n, MD + 1); end
      end else if (fl == 0) begin
         wait_go(n);
         total++; if (n !== MD + 2) begin bad++; $display("FAIL go_after_score got=%0d exp=%0d", n, MD + 2); end
      end else begin
         tick();
         tick();
         repeat (fl - 1) tick();
         if ($urandom % 2) pbl = 1'b1; else pbr = 1'b1;
         tick();
         pbl = 1'b0; pbr = 1'b0;
         total++; if ({foul, go} !== 2'b10 || leds !== exp_leds(pos)) begin bad++; $display("FAIL foul_pulse fl=%0d got=%b leds=%b", fl, {foul, go}, leds); end
         wait_go(n);
         total++; if (n !== MD + 1) begin bad++; $display("FAIL go_after_foul got=%0d exp=%0d", n, MD + 1); end
      end
   endtask

   task automatic test_reset();
      int n;
      #2 rst = 1'b0;
      #1;
      total++; if (leds !== 5'b00100) begin bad++; $display("FAIL reset_leds got=%b exp=00100", leds); end
      total++; if ({clear, go, win_l, win_r, foul} !== 5'b10000) begin bad++; $display("FAIL reset_ctl got=%b exp=10000", {clear, go, win_l, win_r, foul}); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      pos = CTR;
      wait_go(n);
      total++; if (n !== MD + 2) begin bad++; $display("FAIL first_go got=%0d exp=%0d", n, MD + 2); end
      total++; if (clear !== 1'b0) begin bad++; $display("FAIL go_clear got=%b exp=0", clear); end
   endtask

   task automatic test_right_move();
      push_round(1'b0, 1'b1, 0);
      total++; if (leds !== 5'b01000) begin bad++; $display("FAIL right_move got=%b exp=01000", leds); end
   endtask

   task automatic test_win_newgame();
      push_round(1'b0, 1'b1, 0);
      total++; if (leds !== 5'b00100 || win_r !== 1'b0) begin bad++; $display("FAIL after_win leds=%b win_r=%b", leds, win_r); end
   endtask

   task automatic test_foul();
      int n;
      push = 1'b1; tie = 1'b1;
      tick();
      push = 1'b0; tie = 1'b0;
      repeat (4) tick();
      pbl = 1'b1;
      tick();
      total++; if ({foul, go} !== 2'b10 || leds !== exp_leds(pos)) begin bad++; $display("FAIL foul_set got=%b leds=%b", {foul, go}, leds); end
      tick();
      total++; if (foul !== 1'b0) begin bad++; $display("FAIL foul_width got=%b exp=0", foul); end
      new_game = 1'b1;
      repeat (3) tick();
      new_game = 1'b0;
      total++; if ({go, clear} !== 2'b01 || leds !== exp_leds(pos)) begin bad++; $display("FAIL foul_hold got=%b leds=%b", {go, clear}, leds); end
      pbl = 1'b0;
      wait_go(n);
      total++; if (n !== MD + 1) begin bad++; $display("FAIL foul_restart got=%0d exp=%0d", n, MD + 1); end
   endtask

   task automatic go_timeout(input string tag);
      int n;
      n = 0;
      while (go === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      total++; if (n !== GT) begin bad++; $display("FAIL %s_len got=%0d exp=%0d", tag, n, GT); end
      total++; if (leds !== exp_leds(pos) || clear !== 1'b1) begin bad++; $display("FAIL %s_state leds=%b clear=%b", tag, leds, clear); end
      wait_go(n);
      total++; if (n !== MD + 1) begin bad++; $display("FAIL %s_rego got=%0d exp=%0d", tag, n, MD + 1); end
   endtask

   task automatic test_tie_timeout();
      push_round(1'b1, 1'b1, 0);
      go_timeout("timeout");
   endtask

   task automatic test_async_reset();
      int n;
      push_round(1'b0, 1'b0, 0);
      total++; if (leds !== 5'b00010) begin bad++; $display("FAIL pre_reset got=%b exp=00010", leds); end
      #3 rst = 1'b0;
      #1;
      total++; if (leds !== 5'b00100 || {go, clear} !== 2'b01) begin bad++; $display("FAIL async_reset leds=%b ctl=%b", leds, {go, clear}); end
      #1 rst = 1'b1;
      pos = CTR;
      wait_go(n);
      total++; if (n !== MD + 2) begin bad++; $display("FAIL go_after_reset got=%0d exp=%0d", n, MD + 2); end
   endtask

   task automatic test_random();
      int k, fl;
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, GT);
         if (k == GT) begin
            go_timeout("rnd_timeout");
         end else begin
            repeat (k) begin
               new_game = $urandom % 2;
               tick();
            end
            new_game = 1'b0;
            total++; if (go !== 1'b1 || leds !== exp_leds(pos)) begin bad++; $display("FAIL rnd_go_wait go=%b leds=%b exp=%b", go, leds, exp_leds(pos)); end
            fl = ($urandom % 3 == 0) ? $urandom_range(1, MD) : 0;
            push_round(($urandom % 4) == 0, $urandom % 2, fl);
         end
         total++; if ($countones(leds) != 1 || (win_l && win_r)) begin bad++; $display("FAIL rnd_invariant leds=%b wins=%b", leds, {win_l, win_r}); end
      end
   endtask

   initial begin
      test_reset();
      test_right_move();
      test_win_newgame();
      test_foul();
      test_tie_timeout();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
